xor_begin_stage: RTL and testbench

Registered data-injection stage at the input of the ASCON-128 permutation: absorbs 64-bit associated-data, plaintext, or ciphertext blocks into state word 0, applies last-block padding, and injects the key into words 1–2 at finalization. It sits between the data interface and the permutation rounds, complementing the post-permutation key/LSB XOR stage. It uses valid/ready handshakes on its data input, state output, and cipher/plain output.

---
 rtl/ascon_pkg.sv | 10 +
 rtl/xor_begin_stage.sv | 155 +++++++++++++++
 tb/tb_xor_begin_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared ASCON-128 word and state types.
package ascon_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned NUM_WORDS = 5;

  // Word 0 is the rate word; words 1-4 are capacity.
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] t_state_array;

endpackage

// File: rtl/xor_begin_stage.sv
// Pre-permutation injection stage: absorbs AD/PT/CT blocks into word 0 with
// last-block padding, and XORs the key into words 1-2 on finalize.
module xor_begin_stage
  import ascon_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  t_state_array        i_state,
  input  logic [127:0]        i_key,
  input  logic [1:0]          i_mode,
  input  logic [WORD_W-1:0]   i_data,
  input  logic [3:0]          i_data_bytes,
  input  logic                i_data_valid,
  output logic                o_data_ready,
  output t_state_array        o_state,
  output logic                o_state_valid,
  input  logic                i_state_ready,
  output logic [WORD_W-1:0]   o_cipher,
  output logic                o_cipher_valid,
  input  logic                i_cipher_ready
);

  localparam int unsigned BYTES_W   = 4;
  localparam int unsigned NUM_BYTES = WORD_W / 8;

  localparam logic [1:0] MODE_AD  = 2'b00;
  localparam logic [1:0] MODE_ENC = 2'b01;
  localparam logic [1:0] MODE_DEC = 2'b10;
  localparam logic [1:0] MODE_FIN = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fsm_t;

  fsm_t state_q, state_d;

  logic state_pend_q, state_pend_d;
  logic cipher_pend_q, cipher_pend_d;
  logic accept_c;

  logic [BYTES_W-1:0] n_bytes_c;
  logic [WORD_W-1:0]  mask_c;
  logic [WORD_W-1:0]  pad_c;
  logic [WORD_W-1:0]  d_c;
  logic [WORD_W-1:0]  s0_c;
  logic [WORD_W-1:0]  cipher_c;
  t_state_array       state_w_c;

  assign accept_c = (state_q == IDLE) && i_data_valid;

  // Byte mask for the valid prefix and the 0x80 pad byte right after it.
  always_comb begin
    n_bytes_c = (i_data_bytes > BYTES_W'(NUM_BYTES)) ? BYTES_W'(NUM_BYTES) : i_data_bytes;
    mask_c    = '0;
    pad_c     = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (BYTES_W'(b) < n_bytes_c) begin
        mask_c[WORD_W-1-8*b -: 8] = 8'hFF;
      end else if (BYTES_W'(b) == n_bytes_c) begin
        pad_c[WORD_W-1-8*b -: 8] = 8'h80;
      end
    end
  end

  // Absorb / decrypt-overwrite / key-injection datapath.
  always_comb begin
    s0_c      = i_state[0];
    d_c       = i_data & mask_c;
    cipher_c  = (s0_c ^ d_c) & mask_c;
    state_w_c = i_state;
    case (i_mode)
      MODE_DEC: begin
        state_w_c[0] = (d_c | (s0_c & ~mask_c)) ^ pad_c;
      end
      MODE_FIN: begin
        state_w_c[0] = s0_c ^ d_c ^ pad_c;
        state_w_c[1] = i_state[1] ^ i_key[127:64];
        state_w_c[2] = i_state[2] ^ i_key[63:0];
      end
      default: begin
        state_w_c[0] = s0_c ^ d_c ^ pad_c;
      end
    endcase
  end

  // FSM state, pending flags and output data registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      state_pend_q  <= 1'b0;
      cipher_pend_q <= 1'b0;
      o_state       <= '0;
      o_cipher      <= '0;
    end else begin
      state_q       <= state_d;
      state_pend_q  <= state_pend_d;
      cipher_pend_q <= cipher_pend_d;
      if (accept_c) begin
        o_state  <= state_w_c;
        o_cipher <= cipher_c;
      end
    end
  end

  // Next state: leave HOLD on the edge where the last pending handshake completes.
  always_comb begin
    state_d       = state_q;
    state_pend_d  = state_pend_q;
    cipher_pend_d = cipher_pend_q;
    case (state_q)
      IDLE: begin
        if (i_data_valid) begin
          state_d       = HOLD;
          state_pend_d  = 1'b1;
          cipher_pend_d = (i_mode == MODE_ENC) || (i_mode == MODE_DEC);
        end
      end
      HOLD: begin
        state_pend_d  = state_pend_q  && !i_state_ready;
        cipher_pend_d = cipher_pend_q && !i_cipher_ready;
        if (!state_pend_d && !cipher_pend_d) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from registered FSM state and flags only.
  always_comb begin
    o_data_ready   = 1'b0;
    o_state_valid  = 1'b0;
    o_cipher_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_data_ready = 1'b1;
      end
      HOLD: begin
        o_state_valid  = state_pend_q;
        o_cipher_valid = cipher_pend_q;
      end
      default: begin
        o_data_ready = 1'b1;
      end
    endcase
  end

  // Mode encoding kept explicit for readers of the datapath.
  logic unused_mode_c;
  assign unused_mode_c = (MODE_AD == 2'b00);

endmodule

// File: tb/tb_xor_begin_stage.sv
// Directed bench for xor_begin_stage with a byte-level reference model.
module tb_xor_begin_stage;
  import ascon_pkg::*;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  t_state_array       i_state = '0;
  logic [127:0]       i_key = '0;
  logic [1:0]         i_mode = 2'b00;
  logic [63:0]        i_data = '0;
  logic [3:0]         i_data_bytes = 4'd0;
  logic               i_data_valid = 1'b0;
  logic               o_data_ready;
  t_state_array       o_state;
  logic               o_state_valid;
  logic               i_state_ready = 1'b1;
  logic [63:0]        o_cipher;
  logic               o_cipher_valid;
  logic               i_cipher_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  xor_begin_stage dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_state        (i_state),
    .i_key          (i_key),
    .i_mode         (i_mode),
    .i_data         (i_data),
    .i_data_bytes   (i_data_bytes),
    .i_data_valid   (i_data_valid),
    .o_data_ready   (o_data_ready),
    .o_state        (o_state),
    .o_state_valid  (o_state_valid),
    .i_state_ready  (i_state_ready),
    .o_cipher       (o_cipher),
    .o_cipher_valid (o_cipher_valid),
    .i_cipher_ready (i_cipher_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: byte-by-byte absorb of one block.
  function automatic t_state_array f_state(input t_state_array st, input logic [127:0] key,
                                           input logic [1:0] mode, input logic [63:0] data,
                                           input logic [3:0] nb);
    t_state_array r = st;
    int n = (nb > 4'd8) ? 8 : int'(nb);
    logic [7:0] sb, db;
    for (int b = 0; b < 8; b++) begin
      sb = st[0][63-8*b -: 8];
      db = data[63-8*b -: 8];
      if (b < n) r[0][63-8*b -: 8] = (mode == 2'b10) ? db : (sb ^ db);
      else if (b == n) r[0][63-8*b -: 8] = sb ^ 8'h80;
      else r[0][63-8*b -: 8] = sb;
    end
    if (mode == 2'b11) begin
      r[1] = st[1] ^ key[127:64];
      r[2] = st[2] ^ key[63:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] f_cipher(input logic [63:0] s0, input logic [63:0] data,
                                           input logic [3:0] nb);
    logic [63:0] c = '0;
    int n = (nb > 4'd8) ? 8 : int'(nb);
    for (int b = 0; b < n; b++) c[63-8*b -: 8] = s0[63-8*b -: 8] ^ data[63-8*b -: 8];
    return c;
  endfunction

  // Transaction-level model of outstanding outputs.
  logic         m_busy = 1'b0;
  logic         m_sp = 1'b0;
  logic         m_cp = 1'b0;
  t_state_array m_state = '0;
  logic [63:0]  m_cipher = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_sp <= 1'b0; m_cp <= 1'b0;
      m_state <= '0; m_cipher <= '0;
    end else if (!m_busy) begin
      if (i_data_valid) begin
        m_state  <= f_state(i_state, i_key, i_mode, i_data, i_data_bytes);
        m_cipher <= f_cipher(i_state[0], i_data, i_data_bytes);
        m_sp     <= 1'b1;
        m_cp     <= (i_mode == 2'b01) || (i_mode == 2'b10);
        m_busy   <= 1'b1;
      end
    end else begin
      m_sp   <= m_sp && !i_state_ready;
      m_cp   <= m_cp && !i_cipher_ready;
      m_busy <= (m_sp && !i_state_ready) || (m_cp && !i_cipher_ready);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    chk("data_ready", 64'(o_data_ready), 64'(!m_busy));
    chk("state_valid", 64'(o_state_valid), 64'(m_sp));
    chk("cipher_valid", 64'(o_cipher_valid), 64'(m_cp));
    if (m_sp || !reset_n)
      for (int w = 0; w < 5; w++) chk($sformatf("state_w%0d", w), o_state[w], m_state[w]);
    if (m_cp || !reset_n) chk("cipher", o_cipher, m_cipher);
  end

  task automatic send(input logic [1:0] mode, input logic [63:0] data, input logic [3:0] nb,
                      input t_state_array st, input logic [127:0] key);
    logic ok = 1'b0;
    i_mode = mode; i_data = data; i_data_bytes = nb; i_state = st; i_key = key;
    i_data_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (o_data_ready) begin ok = 1'b1; break; end
      @(posedge clock); #1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: o_data_ready never high at %0t", $time);
    end
    @(posedge clock); #1;
    i_data_valid = 1'b0;
    i_data = {$urandom, $urandom};
    i_state[0] = {$urandom, $urandom};
    i_key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  t_state_array st;

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", 64'(o_data_ready), 64'd1);
    chk("rst_svalid", 64'(o_state_valid), 64'd0);
    chk("rst_cvalid", 64'(o_cipher_valid), 64'd0);
    chk("rst_state0", o_state[0], 64'd0);
    chk("rst_cipher", o_cipher, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Encrypt, full block
    st = '{64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222,
           64'h1111111111111111, 64'h0123456789ABCDEF};
    send(2'b01, 64'hFFFFFFFFFFFFFFFF, 4'd8, st, 128'h0);
    @(negedge clock);
    chk("enc_state0", o_state[0], 64'hFEDCBA9876543210);
    chk("enc_state1", o_state[1], 64'h1111111111111111);
    chk("enc_cipher", o_cipher, 64'hFEDCBA9876543210);
    chk("enc_svalid", 64'(o_state_valid), 64'd1);
    chk("enc_cvalid", 64'(o_cipher_valid), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("enc_svalid_drop", 64'(o_state_valid), 64'd0);
    chk("enc_ready_back", 64'(o_data_ready), 64'd1);
    @(posedge clock); #1;

    // Decrypt, partial block
    st[0] = 64'h0123456789ABCDEF;
    send(2'b10, 64'hAABBCC0000000000, 4'd3, st, 128'h0);
    @(negedge clock);
    chk("dec_cipher", o_cipher, 64'hAB98890000000000);
    chk("dec_state0", o_state[0], 64'hAABBCCE789ABCDEF);
    @(posedge clock); #1;

    // Empty AD block
    st[0] = 64'h0;
    send(2'b00, 64'hDEADBEEFDEADBEEF, 4'd0, st, 128'h0);
    @(negedge clock);
    chk("ad_state0", o_state[0], 64'h8000000000000000);
    chk("ad_cvalid", 64'(o_cipher_valid), 64'd0);
    @(posedge clock); #1;

    // Finalize
    st = '{64'h5555AAAA5555AAAA, 64'h0F0F0F0F0F0F0F0F, 64'h0, 64'h0, 64'h0};
    send(2'b11, 64'h0, 4'd8, st, 128'h000102030405060708090A0B0C0D0E0F);
    @(negedge clock);
    chk("fin_state0", o_state[0], 64'h0);
    chk("fin_state1", o_state[1], 64'h0001020304050607);
    chk("fin_state2", o_state[2], 64'h08090A0B0C0D0E0F);
    chk("fin_state3", o_state[3], 64'h0F0F0F0F0F0F0F0F);
    chk("fin_state4", o_state[4], 64'h5555AAAA5555AAAA);
    @(posedge clock); #1;

    // Backpressure on state output only
    i_state_ready = 1'b0;
    st[0] = 64'h0123456789ABCDEF;
    send(2'b01, 64'hFFFFFFFFFFFFFFFF, 4'd8, st, 128'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk("bp_state0", o_state[0], 64'hFEDCBA9876543210);
      chk("bp_svalid", 64'(o_state_valid), 64'd1);
      chk("bp_ready", 64'(o_data_ready), 64'd0);
      chk("bp_cvalid", 64'(o_cipher_valid), (k == 1) ? 64'd1 : 64'd0);
      @(posedge clock); #1;
    end
    i_state_ready = 1'b1;
    @(negedge clock);
    chk("bp_state0_c4", o_state[0], 64'hFEDCBA9876543210);
    chk("bp_ready_c4", 64'(o_data_ready), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_idle", 64'(o_data_ready), 64'd1);
    @(posedge clock); #1;

    // Reset mid-HOLD
    i_state_ready = 1'b0; i_cipher_ready = 1'b0;
    send(2'b01, 64'h1234567812345678, 4'd5, st, 128'h0);
    @(negedge clock);
    chk("rh_svalid", 64'(o_state_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rh_ready", 64'(o_data_ready), 64'd1);
    chk("rh_svalid0", 64'(o_state_valid), 64'd0);
    chk("rh_cvalid0", 64'(o_cipher_valid), 64'd0);
    chk("rh_state0", o_state[0], 64'd0);
    chk("rh_cipher", o_cipher, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    i_state_ready = 1'b1; i_cipher_ready = 1'b1;
    @(posedge clock); #1;
    st[0] = 64'h0123456789ABCDEF;
    send(2'b10, 64'hAABBCC0000000000, 4'd3, st, 128'h0);
    @(negedge clock);
    chk("rh_dec_cipher", o_cipher, 64'hAB98890000000000);
    chk("rh_dec_state0", o_state[0], 64'hAABBCCE789ABCDEF);
    @(posedge clock); #1;

    // Sweep byte counts 0..15 over all modes with random backpressure
    for (int i = 0; i < 16; i++) begin
      for (int w = 0; w < 5; w++) st[w] = {$urandom, $urandom};
      send(2'(i), {$urandom, $urandom}, 4'(i), st, {$urandom, $urandom, $urandom, $urandom});
      for (int k = 0; k < 12; k++) begin
        i_state_ready = 1'($urandom);
        i_cipher_ready = 1'($urandom);
        @(negedge clock);
        if (o_data_ready) break;
        @(posedge clock); #1;
      end
      i_state_ready = 1'b1; i_cipher_ready = 1'b1;
    end
    repeat (4) @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

endmodule
